// File: rtl/dma_axi_adapter_if.sv
// rtl/dma_axi_adapter_if.sv - AXI3 AW/W/B/AR/R channel bundle for dma_axi_adapter
interface dma_axi_adapter_if;
  // Write address channel
  logic [31:0] axi_awaddr;
  logic [5:0]  axi_awid;
  logic [3:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic [3:0]  axi_awcache;
  logic [2:0]  axi_awprot;
  logic        axi_awvalid;
  logic        axi_awready;
  // Write data channel
  logic [63:0] axi_wdata;
  logic [5:0]  axi_wid;
  logic [7:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_wvalid;
  logic        axi_wready;
  // Write response channel
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  // Read address channel
  logic [31:0] axi_araddr;
  logic [5:0]  axi_arid;
  logic [3:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic [3:0]  axi_arcache;
  logic [2:0]  axi_arprot;
  logic        axi_arvalid;
  logic        axi_arready;
  // Read data channel
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready;

  modport master (
    output axi_awaddr, axi_awid, axi_awlen, axi_awsize, axi_awburst, axi_awcache, axi_awprot, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wid, axi_wstrb, axi_wlast, axi_wvalid,
    input  axi_wready,
    input  axi_bresp, axi_bvalid,
    output axi_bready,
    output axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst, axi_arcache, axi_arprot, axi_arvalid,
    input  axi_arready,
    input  axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    output axi_rready
  );

  modport slave (
    input  axi_awaddr, axi_awid, axi_awlen, axi_awsize, axi_awburst, axi_awcache, axi_awprot, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wid, axi_wstrb, axi_wlast, axi_wvalid,
    output axi_wready,
    output axi_bresp, axi_bvalid,
    input  axi_bready,
    input  axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst, axi_arcache, axi_arprot, axi_arvalid,
    output axi_arready,
    output axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    input  axi_rready
  );
endinterface

// File: rtl/dma_axi_adapter.sv
// rtl/dma_axi_adapter.sv - 16-beat 64-bit AXI3 burst engine between dma_control FIFOs and AXI-HP
module dma_axi_adapter #(
  parameter logic [5:0] AXI_ID   = 6'd0,
  parameter int         MIN_BUSY = 4
) (
  input  logic                hclk,
  input  logic                rst_n,
  input  logic [24:0]         cmd_addr,
  input  logic                cmd_type,
  input  logic                cmd_val,
  output logic                cmd_busy,
  input  logic [63:0]         to_data,
  input  logic                to_val,
  output logic                to_ack,
  output logic [63:0]         from_data,
  output logic                from_val,
  input  logic                from_ack,
  output logic                err,
  input  logic                err_clr,
  dma_axi_adapter_if.master   axi
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_HOLD
  } state_t;

  // Busy counter only needs to reach MIN_BUSY, where it saturates.
  localparam int            BW       = $clog2(MIN_BUSY + 1) + 1;
  localparam logic [BW-1:0] BUSY_SAT = BW'(MIN_BUSY);

  state_t        state;
  logic          cmd_val_d;
  logic          cmd_rise;
  logic [24:0]   addr_q;
  logic [3:0]    beat;
  logic [BW-1:0] busy_cnt;
  logic          err_q;

  logic          last_beat;
  logic          r_xfer;
  logic          w_xfer;
  logic          min_done;
  logic          err_set;

  assign last_beat = (beat == 4'd15);
  assign r_xfer    = (state == ST_R) & axi.axi_rvalid & from_ack;
  assign w_xfer    = (state == ST_W) & to_val & axi.axi_wready;
  // busy_cnt counts edges already spent busy; the edge leaving HOLD is one more.
  assign min_done  = (32'(busy_cnt) + 32'd1) >= 32'(MIN_BUSY);

  // Bad rlast placement, non-OKAY rresp on a taken beat, or non-OKAY bresp.
  assign err_set = (r_xfer & ((axi.axi_rlast != last_beat) | (axi.axi_rresp != 2'd0))) |
                   ((state == ST_B) & axi.axi_bvalid & (axi.axi_bresp != 2'd0));

  // Command edge detect, burst sequencing, beat/busy counters and sticky error.
  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_val_d <= 1'b0;
      cmd_rise  <= 1'b0;
      addr_q    <= 25'd0;
      beat      <= 4'd0;
      busy_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      cmd_val_d <= cmd_val;
      cmd_rise  <= cmd_val & ~cmd_val_d;

      if (err_clr) begin
        err_q <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end

      if ((state != ST_IDLE) && (busy_cnt != BUSY_SAT)) begin
        busy_cnt <= busy_cnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (cmd_rise) begin
            addr_q   <= cmd_addr;
            beat     <= 4'd0;
            busy_cnt <= '0;
            state    <= cmd_type ? ST_AW : ST_AR;
          end
        end
        ST_AR: begin
          if (axi.axi_arready) state <= ST_R;
        end
        ST_R: begin
          if (r_xfer) begin
            beat <= beat + 4'd1;
            if (last_beat) state <= ST_HOLD;
          end
        end
        ST_AW: begin
          if (axi.axi_awready) state <= ST_W;
        end
        ST_W: begin
          if (w_xfer) begin
            beat <= beat + 4'd1;
            if (last_beat) state <= ST_B;
          end
        end
        ST_B: begin
          if (axi.axi_bvalid) state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (min_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_busy = (state != ST_IDLE);
  assign err      = err_q;

  // Address channels: valids come straight from the state register.
  assign axi.axi_awaddr  = {addr_q, 7'h0};
  assign axi.axi_awid    = AXI_ID;
  assign axi.axi_awlen   = 4'd15;
  assign axi.axi_awsize  = 3'd3;
  assign axi.axi_awburst = 2'b01;
  assign axi.axi_awcache = 4'b0011;
  assign axi.axi_awprot  = 3'd0;
  assign axi.axi_awvalid = (state == ST_AW);

  assign axi.axi_araddr  = {addr_q, 7'h0};
  assign axi.axi_arid    = AXI_ID;
  assign axi.axi_arlen   = 4'd15;
  assign axi.axi_arsize  = 3'd3;
  assign axi.axi_arburst = 2'b01;
  assign axi.axi_arcache = 4'b0011;
  assign axi.axi_arprot  = 3'd0;
  assign axi.axi_arvalid = (state == ST_AR);

  // Write data: zero-latency pass-through from the to-memory FIFO.
  assign axi.axi_wdata  = (state == ST_W) ? to_data : 64'd0;
  assign axi.axi_wid    = AXI_ID;
  assign axi.axi_wstrb  = 8'hff;
  assign axi.axi_wlast  = (state == ST_W) & last_beat;
  assign axi.axi_wvalid = (state == ST_W) & to_val;
  assign to_ack         = w_xfer;

  assign axi.axi_bready = (state == ST_B);

  // Read data: zero-latency pass-through into the from-memory FIFO.
  assign from_val       = (state == ST_R) & axi.axi_rvalid;
  assign from_data      = (state == ST_R) ? axi.axi_rdata : 64'd0;
  assign axi.axi_rready = (state == ST_R) & from_ack;

endmodule

// File: tb/tb_dma_axi_adapter.sv
// tb/tb_dma_axi_adapter.sv - directed/randomized self-checking bench for dma_axi_adapter
module tb_dma_axi_adapter;
  localparam logic [5:0] ID = 6'h2a;

  logic        hclk = 1'b0;
  logic        rst_n = 1'b1;
  logic [24:0] cmd_addr = '0;
  logic        cmd_type = 1'b0;
  logic        cmd_val = 1'b0;
  logic        cmd_busy;
  logic [63:0] to_data = '0;
  logic        to_val = 1'b0;
  logic        to_ack;
  logic [63:0] from_data;
  logic        from_val;
  logic        from_ack = 1'b0;
  logic        err;
  logic        err_clr = 1'b0;

  dma_axi_adapter_if axi_if ();

  dma_axi_adapter #(.AXI_ID(ID), .MIN_BUSY(4)) dut (
    .hclk      (hclk),
    .rst_n     (rst_n),
    .cmd_addr  (cmd_addr),
    .cmd_type  (cmd_type),
    .cmd_val   (cmd_val),
    .cmd_busy  (cmd_busy),
    .to_data   (to_data),
    .to_val    (to_val),
    .to_ack    (to_ack),
    .from_data (from_data),
    .from_val  (from_val),
    .from_ack  (from_ack),
    .err       (err),
    .err_clr   (err_clr),
    .axi       (axi_if)
  );

  always #5 hclk = ~hclk;

  int   total = 0;
  int   passed = 0;
  logic err_exp = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Raise cmd_val at a negedge and verify the two-edge acceptance latency.
  task automatic start_cmd(input logic [24:0] a, input logic t);
    @(negedge hclk);
    cmd_addr = a;
    cmd_type = t;
    cmd_val  = 1'b1;
    #1;
    check("busy_at_rise", 64'(cmd_busy), 64'd0);
    @(negedge hclk);
    check("busy_edge1", 64'(cmd_busy), 64'd0);
    @(negedge hclk);
    check("busy_edge2", 64'(cmd_busy), 64'd1);
    if (t) check("awvalid_edge2", 64'(axi_if.axi_awvalid), 64'd1);
    else   check("arvalid_edge2", 64'(axi_if.axi_arvalid), 64'd1);
  endtask

  task automatic do_read(input logic [24:0] a, input bit hold, input int bad_beat, input int last_at);
    logic [63:0] d;
    int          beats;
    bit          done;
    start_cmd(a, 1'b0);
    if (!hold) cmd_val = 1'b0;
    check("araddr", 64'(axi_if.axi_araddr), 64'({a, 7'h0}));
    check("arlen", 64'(axi_if.axi_arlen), 64'd15);
    check("arid", 64'(axi_if.axi_arid), 64'(ID));
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      axi_if.axi_arready = 1'($urandom);
      #1;
      check("arvalid_hold", 64'(axi_if.axi_arvalid), 64'd1);
      if (axi_if.axi_arready) done = 1'b1;
      @(negedge hclk);
    end
    axi_if.axi_arready = 1'b0;
    if (!done) check("ar_timeout", 64'd0, 64'd1);
    #1;
    check("arvalid_drop", 64'(axi_if.axi_arvalid), 64'd0);
    beats = 0;
    for (int c = 0; c < 400 && beats < 16; c++) begin
      d = {$urandom, $urandom};
      axi_if.axi_rvalid = ($urandom % 4) != 0;
      axi_if.axi_rdata  = d;
      axi_if.axi_rresp  = (beats == bad_beat) ? 2'd2 : 2'd0;
      axi_if.axi_rlast  = (last_at >= 0) ? (beats == last_at) : (beats == 15);
      from_ack = ($urandom % 4) != 0;
      #1;
      check("from_val", 64'(from_val), 64'(axi_if.axi_rvalid));
      check("rready", 64'(axi_if.axi_rready), 64'(from_ack));
      if (axi_if.axi_rvalid) check("from_data", from_data, d);
      if (axi_if.axi_rvalid && from_ack) begin
        if (axi_if.axi_rresp != 2'd0 || axi_if.axi_rlast != (beats == 15)) err_exp = 1'b1;
        beats++;
      end
      @(negedge hclk);
    end
    if (beats < 16) check("r_timeout", 64'(beats), 64'd16);
    // A 17th beat offered must be refused; busy falls one edge after beat 15.
    axi_if.axi_rvalid = 1'b1;
    axi_if.axi_rlast  = 1'b0;
    axi_if.axi_rresp  = 2'd0;
    from_ack = 1'b1;
    #1;
    check("rready_after", 64'(axi_if.axi_rready), 64'd0);
    check("from_val_after", 64'(from_val), 64'd0);
    check("busy_hold", 64'(cmd_busy), 64'd1);
    check("err_read", 64'(err), 64'(err_exp));
    @(negedge hclk);
    axi_if.axi_rvalid = 1'b0;
    from_ack = 1'b0;
    #1;
    check("busy_fall_read", 64'(cmd_busy), 64'd0);
  endtask

  task automatic do_write(input logic [24:0] a, input bit stall, input int reset_beat, input logic [1:0] bresp);
    int beats;
    int acks;
    int gap;
    bit done;
    start_cmd(a, 1'b1);
    cmd_val = 1'b0;
    check("awaddr", 64'(axi_if.axi_awaddr), 64'({a, 7'h0}));
    check("awlen", 64'(axi_if.axi_awlen), 64'd15);
    check("awid", 64'(axi_if.axi_awid), 64'(ID));
    check("awsize", 64'(axi_if.axi_awsize), 64'd3);
    check("awburst", 64'(axi_if.axi_awburst), 64'd1);
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      axi_if.axi_awready = 1'($urandom);
      #1;
      check("awvalid_hold", 64'(axi_if.axi_awvalid), 64'd1);
      if (axi_if.axi_awready) done = 1'b1;
      @(negedge hclk);
    end
    axi_if.axi_awready = 1'b0;
    if (!done) check("aw_timeout", 64'd0, 64'd1);
    beats = 0;
    acks  = 0;
    for (int c = 0; c < 400 && beats < 16; c++) begin
      to_data = {$urandom, $urandom};
      to_val  = stall ? 1'($urandom) : 1'b1;
      axi_if.axi_wready = stall ? 1'($urandom) : 1'b1;
      if (beats == reset_beat) begin
        to_val = 1'b1;
        axi_if.axi_wready = 1'b1;
      end
      #1;
      check("wvalid", 64'(axi_if.axi_wvalid), 64'(to_val));
      check("to_ack", 64'(to_ack), 64'(to_val & axi_if.axi_wready));
      if (to_val) begin
        check("wdata", axi_if.axi_wdata, to_data);
        check("wlast", 64'(axi_if.axi_wlast), 64'(beats == 15));
        check("wid", 64'(axi_if.axi_wid), 64'(ID));
        check("wstrb", 64'(axi_if.axi_wstrb), 64'hff);
      end
      if (beats == reset_beat) begin
        rst_n = 1'b0;
        #1;
        check("rst_wvalid", 64'(axi_if.axi_wvalid), 64'd0);
        check("rst_to_ack", 64'(to_ack), 64'd0);
        check("rst_busy", 64'(cmd_busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        to_val = 1'b0;
        axi_if.axi_wready = 1'b0;
        err_exp = 1'b0;
        @(negedge hclk);
        rst_n = 1'b1;
        @(negedge hclk);
        return;
      end
      if (to_ack) acks++;
      if (to_val && axi_if.axi_wready) beats++;
      @(negedge hclk);
    end
    if (beats < 16) check("w_timeout", 64'(beats), 64'd16);
    check("ack_count", 64'(acks), 64'd16);
    to_val = 1'b1;
    axi_if.axi_wready = 1'b1;
    gap = $urandom_range(0, 3);
    for (int c = 0; c < gap; c++) begin
      #1;
      check("bready_wait", 64'(axi_if.axi_bready), 64'd1);
      check("to_ack_extra", 64'(to_ack), 64'd0);
      check("wvalid_extra", 64'(axi_if.axi_wvalid), 64'd0);
      @(negedge hclk);
    end
    axi_if.axi_bvalid = 1'b1;
    axi_if.axi_bresp  = bresp;
    if (bresp != 2'd0) err_exp = 1'b1;
    #1;
    check("bready", 64'(axi_if.axi_bready), 64'd1);
    @(negedge hclk);
    axi_if.axi_bvalid = 1'b0;
    axi_if.axi_bresp  = 2'd0;
    to_val = 1'b0;
    axi_if.axi_wready = 1'b0;
    #1;
    check("busy_after_b", 64'(cmd_busy), 64'd1);
    check("err_write", 64'(err), 64'(err_exp));
    @(negedge hclk);
    #1;
    check("busy_fall_write", 64'(cmd_busy), 64'd0);
  endtask

  task automatic clear_err();
    @(negedge hclk);
    err_clr = 1'b1;
    @(negedge hclk);
    err_clr = 1'b0;
    #1;
    check("err_clr", 64'(err), 64'd0);
    err_exp = 1'b0;
  endtask

  initial begin
    axi_if.axi_awready = 1'b0;
    axi_if.axi_wready  = 1'b0;
    axi_if.axi_bresp   = 2'd0;
    axi_if.axi_bvalid  = 1'b0;
    axi_if.axi_arready = 1'b0;
    axi_if.axi_rdata   = '0;
    axi_if.axi_rresp   = 2'd0;
    axi_if.axi_rlast   = 1'b0;
    axi_if.axi_rvalid  = 1'b0;
    #2;
    rst_n = 1'b0;
    #10;
    check("rst_cmd_busy", 64'(cmd_busy), 64'd0);
    check("rst_arvalid", 64'(axi_if.axi_arvalid), 64'd0);
    check("rst_awvalid", 64'(axi_if.axi_awvalid), 64'd0);
    check("rst_wvalid0", 64'(axi_if.axi_wvalid), 64'd0);
    check("rst_bready", 64'(axi_if.axi_bready), 64'd0);
    check("rst_rready", 64'(axi_if.axi_rready), 64'd0);
    check("rst_from_val", 64'(from_val), 64'd0);
    check("rst_err0", 64'(err), 64'd0);
    check("rst_araddr", 64'(axi_if.axi_araddr), 64'd0);
    check("rst_arlen", 64'(axi_if.axi_arlen), 64'd15);
    check("rst_awlen", 64'(axi_if.axi_awlen), 64'd15);
    check("rst_wstrb", 64'(axi_if.axi_wstrb), 64'hff);
    check("rst_arid", 64'(axi_if.axi_arid), 64'(ID));
    repeat (3) @(negedge hclk);
    rst_n = 1'b1;
    @(negedge hclk);

    do_read(25'h000_0001, 1'b0, -1, -1);
    do_write(25'(($urandom)), 1'b1, -1, 2'd0);

    do_read(25'(($urandom)), 1'b1, -1, -1);
    for (int c = 0; c < 8; c++) begin
      @(negedge hclk);
      #1;
      check("level_no_busy", 64'(cmd_busy), 64'd0);
      check("level_no_ar", 64'(axi_if.axi_arvalid), 64'd0);
    end
    cmd_val = 1'b0;
    @(negedge hclk);
    do_read(25'(($urandom)), 1'b0, -1, -1);

    do_read(25'(($urandom)), 1'b0, 5, -1);
    check("err_rresp", 64'(err), 64'd1);
    clear_err();
    do_read(25'(($urandom)), 1'b0, -1, 9);
    check("err_rlast", 64'(err), 64'd1);
    clear_err();
    do_write(25'(($urandom)), 1'b0, -1, 2'd2);
    check("err_bresp", 64'(err), 64'd1);
    clear_err();

    do_write(25'(($urandom)), 1'b1, 7, 2'd0);
    do_read(25'(($urandom)), 1'b0, -1, -1);

    for (int i = 0; i < 4; i++) begin
      if (($urandom % 2) != 0) do_write(25'(($urandom)), 1'b1, -1, 2'd0);
      else                     do_read(25'(($urandom)), 1'b0, -1, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
